// File: rtl/cdb_wb_if.sv
// Result/broadcast bundle between the functional-unit channels, the writeback arbiter and the CDB.
// The arbiter uses the slave view; whoever produces results and consumes broadcasts uses master.
interface cdb_wb_if #(
   parameter int NUM_FU    = 5,
   parameter int NUM_CDB   = 2,
   parameter int PAYLOAD_W = 80,
   parameter int SRC_W     = $clog2(NUM_FU)
);
   logic [NUM_FU-1:0]            fu_valid;
   logic [NUM_FU*PAYLOAD_W-1:0]  fu_payload;
   logic [NUM_FU-1:0]            fu_ready;
   logic [NUM_CDB-1:0]           cdb_valid;
   logic [NUM_CDB*PAYLOAD_W-1:0] cdb_payload;
   logic [NUM_CDB*SRC_W-1:0]     cdb_src;

   modport master (
      output fu_valid,
      output fu_payload,
      input  fu_ready,
      input  cdb_valid,
      input  cdb_payload,
      input  cdb_src
   );

   modport slave (
      input  fu_valid,
      input  fu_payload,
      output fu_ready,
      output cdb_valid,
      output cdb_payload,
      output cdb_src
   );
endinterface

// File: rtl/cdb_wb_arbiter.sv
// Writeback arbiter: per-FU result FIFOs drained round-robin onto NUM_CDB broadcast ports.
// Optional feature macro CDB_WB_STATS_EN adds saturating per-channel stall counters (stall_cnt).
module cdb_wb_arbiter #(
   parameter int NUM_FU     = 5,
   parameter int NUM_CDB    = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int PAYLOAD_W  = 80
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    flush,
   cdb_wb_if.slave bus
`ifdef CDB_WB_STATS_EN
   ,
   output logic [NUM_FU*32-1:0] stall_cnt
`endif
);
   localparam int SRC_W = $clog2(NUM_FU);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   logic [PAYLOAD_W-1:0] mem    [NUM_FU][FIFO_DEPTH];
   logic [PTR_W-1:0]     rd_ptr [NUM_FU];
   logic [PTR_W-1:0]     wr_ptr [NUM_FU];
   logic [CNT_W-1:0]     count  [NUM_FU];
   logic [SRC_W-1:0]     rr_ptr;

   logic [NUM_FU-1:0]    not_empty;
   logic [NUM_FU-1:0]    full;
   logic [NUM_FU-1:0]    push;
   logic [NUM_FU-1:0]    grant;
   logic [PAYLOAD_W-1:0] head [NUM_FU];

   logic [NUM_CDB-1:0]   port_used;
   logic [SRC_W-1:0]     port_ch [NUM_CDB];
   logic [SRC_W-1:0]     rr_next;

   // Ready looks only at registered occupancy, so a full FIFO refuses even while it is being popped.
   always_comb begin
      for (int i = 0; i < NUM_FU; i++) begin
         not_empty[i] = (count[i] != '0);
         full[i]      = (count[i] == CNT_W'(FIFO_DEPTH));
         head[i]      = mem[i][rd_ptr[i]];
         push[i]      = bus.fu_valid[i] && rst && !full[i] && !flush;
      end
   end

   assign bus.fu_ready = rst ? ~full : '0;

   always_comb begin
      logic [SRC_W-1:0] ch;
      int               n;
      ch        = '0;
      n         = 0;
      grant     = '0;
      port_used = '0;
      rr_next   = rr_ptr;
      for (int p = 0; p < NUM_CDB; p++) begin
         port_ch[p] = '0;
      end
      for (int k = 0; k < NUM_FU; k++) begin
         ch = SRC_W'((int'(rr_ptr) + k) % NUM_FU);
         if (not_empty[ch] && (n < NUM_CDB)) begin
            grant[ch] = 1'b1;
            for (int p = 0; p < NUM_CDB; p++) begin
               if (n == p) begin
                  port_used[p] = 1'b1;
                  port_ch[p]   = ch;
               end
            end
            rr_next = SRC_W'((int'(ch) + 1) % NUM_FU);
            n       = n + 1;
         end
      end
   end

   // Flush suppresses the broadcast combinationally; the pops it would imply are discarded anyway.
   always_comb begin
      bus.cdb_valid   = '0;
      bus.cdb_payload = '0;
      bus.cdb_src     = '0;
      if (rst && !flush) begin
         for (int p = 0; p < NUM_CDB; p++) begin
            if (port_used[p]) begin
               bus.cdb_valid[p]                          = 1'b1;
               bus.cdb_payload[p*PAYLOAD_W +: PAYLOAD_W] = head[port_ch[p]];
               bus.cdb_src[p*SRC_W +: SRC_W]             = port_ch[p];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         for (int i = 0; i < NUM_FU; i++) begin
            rd_ptr[i] <= '0;
            wr_ptr[i] <= '0;
            count[i]  <= '0;
         end
         rr_ptr <= '0;
      end else begin
         for (int i = 0; i < NUM_FU; i++) begin
            if (push[i]) begin
               wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
            end
            if (grant[i]) begin
               rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
            end
            count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(grant[i]);
         end
         rr_ptr <= rr_next;
      end
   end

   // Storage has no reset; only the pointers decide what is live.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_FU; i++) begin
         if (push[i]) begin
            mem[i][wr_ptr[i]] <= bus.fu_payload[i*PAYLOAD_W +: PAYLOAD_W];
         end
      end
   end

`ifdef CDB_WB_STATS_EN
   logic [31:0] stall_q [NUM_FU];

   // Counters survive flush on purpose so mispredict-heavy phases still show up in the stats.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NUM_FU; i++) begin
            stall_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_FU; i++) begin
            if (not_empty[i] && !grant[i] && (stall_q[i] != 32'hFFFF_FFFF)) begin
               stall_q[i] <= stall_q[i] + 32'd1;
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_FU; i++) begin
         stall_cnt[i*32 +: 32] = stall_q[i];
      end
   end
`endif

endmodule

// File: tb/tb_cdb_wb_arbiter.sv
// Self-checking bench for cdb_wb_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the writeback rules.
module tb_cdb_wb_arbiter;
   localparam int NF    = 4;
   localparam int NC    = 2;
   localparam int DEPTH = 4;
   localparam int PW    = 16;
   localparam int SW    = 2;

   logic clk = 1'b0;
   logic rst;
   logic flush;
   int   tests_run    = 0;
   int   tests_failed = 0;

   cdb_wb_if #(.NUM_FU(NF), .NUM_CDB(NC), .PAYLOAD_W(PW)) bus ();

`ifdef CDB_WB_STATS_EN
   logic [NF*32-1:0] stall_cnt;
`endif

   cdb_wb_arbiter #(
      .NUM_FU(NF), .NUM_CDB(NC), .FIFO_DEPTH(DEPTH), .PAYLOAD_W(PW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .flush(flush),
      .bus(bus)
`ifdef CDB_WB_STATS_EN
      ,
      .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: one queue per channel, a round-robin start index and stall tallies.
   logic [PW-1:0]   mq [NF][$];
   int              m_rr;
   longint unsigned m_stall [NF];

   logic [NF-1:0]    exp_ready;
   logic [NC-1:0]    exp_valid;
   logic [NC*PW-1:0] exp_payload;
   logic [NC*SW-1:0] exp_src;
   int               gr_ch [NC];
   int               n_gr;

   function automatic void compute_expected();
      int ch;
      exp_ready   = '0;
      exp_valid   = '0;
      exp_payload = '0;
      exp_src     = '0;
      n_gr        = 0;
      if (rst === 1'b1) begin
         for (int i = 0; i < NF; i++) exp_ready[i] = (mq[i].size() < DEPTH);
         for (int k = 0; k < NF; k++) begin
            ch = (m_rr + k) % NF;
            if (mq[ch].size() > 0 && n_gr < NC) begin
               gr_ch[n_gr] = ch;
               if (flush !== 1'b1) begin
                  exp_valid[n_gr]              = 1'b1;
                  exp_payload[n_gr*PW +: PW]   = mq[ch][0];
                  exp_src[n_gr*SW +: SW]       = SW'(ch);
               end
               n_gr++;
            end
         end
      end
   endfunction

   function automatic void advance_model();
      bit granted;
      compute_expected();
      if (rst !== 1'b1) begin
         for (int i = 0; i < NF; i++) begin
            mq[i].delete();
            m_stall[i] = 0;
         end
         m_rr = 0;
      end else begin
         for (int i = 0; i < NF; i++) begin
            granted = 1'b0;
            for (int g = 0; g < n_gr; g++) if (gr_ch[g] == i) granted = 1'b1;
            if (mq[i].size() > 0 && !granted && m_stall[i] < 64'hFFFF_FFFF) m_stall[i]++;
         end
         if (flush === 1'b1) begin
            for (int i = 0; i < NF; i++) mq[i].delete();
            m_rr = 0;
         end else begin
            for (int g = 0; g < n_gr; g++) void'(mq[gr_ch[g]].pop_front());
            for (int i = 0; i < NF; i++)
               if (bus.fu_valid[i] && exp_ready[i]) mq[i].push_back(bus.fu_payload[i*PW +: PW]);
            if (n_gr > 0) m_rr = (gr_ch[n_gr-1] + 1) % NF;
         end
      end
   endfunction

   task automatic tick();
      advance_model();
      @(posedge clk);
      #1;
   endtask

   task automatic set_inputs(input logic r, input logic f, input logic [NF-1:0] v,
                             input logic [NF*PW-1:0] p);
      rst            = r;
      flush          = f;
      bus.fu_valid   = v;
      bus.fu_payload = p;
   endtask

   function automatic logic [NF*PW-1:0] rand_payload();
      logic [NF*PW-1:0] p;
      for (int i = 0; i < NF; i++) p[i*PW +: PW] = PW'($urandom);
      return p;
   endfunction

   task automatic test_reset();
      set_inputs(1'b0, 1'b0, 4'hF, rand_payload());
      #3;
      tests_run++;
      if (bus.fu_ready !== 4'h0) begin
         tests_failed++;
         $display("[TB] FAIL reset_ready: got %h expected 0", bus.fu_ready);
      end
      tests_run++;
      if (bus.cdb_valid !== 2'b00) begin
         tests_failed++;
         $display("[TB] FAIL reset_valid: got %b expected 00", bus.cdb_valid);
      end
      tests_run++;
      if (bus.cdb_payload !== '0 || bus.cdb_src !== '0) begin
         tests_failed++;
         $display("[TB] FAIL reset_payload_src: got %h/%h expected 0/0", bus.cdb_payload, bus.cdb_src);
      end
      tick();
      tick();
   endtask

   task automatic test_single_push();
      set_inputs(1'b1, 1'b0, 4'b0100, {16'h0000, 16'hA5A5, 16'h0000, 16'h0000});
      #3;
      tests_run++;
      if (bus.fu_ready !== 4'hF || bus.cdb_valid !== 2'b00) begin
         tests_failed++;
         $display("[TB] FAIL single_push_cycle: got ready=%h valid=%b expected F/00",
                  bus.fu_ready, bus.cdb_valid);
      end
      tick();
      set_inputs(1'b1, 1'b0, 4'h0, '0);
      #3;
      tests_run++;
      if (bus.cdb_valid !== 2'b01 || bus.cdb_payload !== 32'h0000_A5A5 || bus.cdb_src !== 4'b0010) begin
         tests_failed++;
         $display("[TB] FAIL single_push_bcast: got v=%b p=%h s=%b expected 01/0000a5a5/0010",
                  bus.cdb_valid, bus.cdb_payload, bus.cdb_src);
      end
      tick();
      #3;
      tests_run++;
      if (bus.cdb_valid !== 2'b00) begin
         tests_failed++;
         $display("[TB] FAIL single_push_empty: got %b expected 00", bus.cdb_valid);
      end
      tick();
   endtask

   task automatic test_all_channels();
      logic [NF*PW-1:0] p;
      set_inputs(1'b0, 1'b0, 4'h0, '0);
      tick();
      for (int i = 0; i < NF; i++) p[i*PW +: PW] = PW'(16'h1000 + i);
      set_inputs(1'b1, 1'b0, 4'hF, p);
      tick();
      set_inputs(1'b1, 1'b0, 4'h0, '0);
      #3;
      tests_run++;
      if (bus.cdb_valid !== 2'b11 || bus.cdb_src !== 4'b0100 || bus.cdb_payload !== 32'h1001_1000) begin
         tests_failed++;
         $display("[TB] FAIL all_ch_first: got v=%b s=%b p=%h expected 11/0100/10011000",
                  bus.cdb_valid, bus.cdb_src, bus.cdb_payload);
      end
      tick();
      #3;
      tests_run++;
      if (bus.cdb_valid !== 2'b11 || bus.cdb_src !== 4'b1110 || bus.cdb_payload !== 32'h1003_1002) begin
         tests_failed++;
         $display("[TB] FAIL all_ch_second: got v=%b s=%b p=%h expected 11/1110/10031002",
                  bus.cdb_valid, bus.cdb_src, bus.cdb_payload);
      end
      tick();
      #3;
      tests_run++;
      if (bus.cdb_valid !== 2'b00) begin
         tests_failed++;
         $display("[TB] FAIL all_ch_idle: got %b expected 00", bus.cdb_valid);
      end
      tick();
      // With the pointer back at 0, channel 0 must win port 0 over channel 3.
      set_inputs(1'b1, 1'b0, 4'b1001, {16'h2003, 16'h0000, 16'h0000, 16'h2000});
      tick();
      set_inputs(1'b1, 1'b0, 4'h0, '0);
      #3;
      tests_run++;
      if (bus.cdb_valid !== 2'b11 || bus.cdb_src !== 4'b1100 || bus.cdb_payload !== 32'h2003_2000) begin
         tests_failed++;
         $display("[TB] FAIL all_ch_rr_zero: got v=%b s=%b p=%h expected 11/1100/20032000",
                  bus.cdb_valid, bus.cdb_src, bus.cdb_payload);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [PW-1:0]    seen [$];
      logic [NF*PW-1:0] p;
      int               next_val    = 1;
      int               accepted    = 0;
      bit               saw_refusal = 1'b0;
      int               cyc         = 0;
      while ((accepted < 5 || !saw_refusal) && cyc < 40) begin
         p = rand_payload();
         p[PW +: PW] = PW'(next_val);
         set_inputs(1'b1, 1'b0, 4'hF, p);
         #3;
         compute_expected();
         tests_run++;
         if (bus.fu_ready !== exp_ready || bus.cdb_valid !== exp_valid ||
             bus.cdb_payload !== exp_payload || bus.cdb_src !== exp_src) begin
            tests_failed++;
            $display("[TB] FAIL b2b_cycle%0d: got r=%h v=%b p=%h s=%b expected r=%h v=%b p=%h s=%b", cyc,
                     bus.fu_ready, bus.cdb_valid, bus.cdb_payload, bus.cdb_src,
                     exp_ready, exp_valid, exp_payload, exp_src);
         end
         for (int k = 0; k < NC; k++)
            if (bus.cdb_valid[k] === 1'b1 && bus.cdb_src[k*SW +: SW] === 2'd1)
               seen.push_back(bus.cdb_payload[k*PW +: PW]);
         if (bus.fu_ready[1] === 1'b1) begin
            accepted++;
            next_val++;
         end else begin
            saw_refusal = 1'b1;
         end
         tick();
         cyc++;
      end
      set_inputs(1'b1, 1'b0, 4'h0, '0);
      repeat (12) begin
         #3;
         compute_expected();
         tests_run++;
         if (bus.cdb_valid !== exp_valid || bus.cdb_payload !== exp_payload || bus.cdb_src !== exp_src) begin
            tests_failed++;
            $display("[TB] FAIL b2b_drain: got v=%b p=%h s=%b expected v=%b p=%h s=%b",
                     bus.cdb_valid, bus.cdb_payload, bus.cdb_src, exp_valid, exp_payload, exp_src);
         end
         for (int k = 0; k < NC; k++)
            if (bus.cdb_valid[k] === 1'b1 && bus.cdb_src[k*SW +: SW] === 2'd1)
               seen.push_back(bus.cdb_payload[k*PW +: PW]);
         tick();
      end
      tests_run++;
      if (!saw_refusal || accepted < 5) begin
         tests_failed++;
         $display("[TB] FAIL b2b_full: got refusal=%0d accepted=%0d expected refusal=1 accepted>=5",
                  saw_refusal, accepted);
      end
      tests_run++;
      if (seen.size() != accepted) begin
         tests_failed++;
         $display("[TB] FAIL b2b_count: got %0d results expected %0d", seen.size(), accepted);
      end else begin
         for (int j = 0; j < accepted; j++) begin
            if (seen[j] !== PW'(j + 1)) begin
               tests_failed++;
               $display("[TB] FAIL b2b_order: got %h at %0d expected %h", seen[j], j, PW'(j + 1));
               break;
            end
         end
      end
   endtask

   task automatic test_flush();
      repeat (5) begin
         set_inputs(1'b1, 1'b0, 4'hF, rand_payload());
         tick();
      end
      set_inputs(1'b1, 1'b1, 4'hF, rand_payload());
      #3;
      tests_run++;
      if (bus.cdb_valid !== 2'b00) begin
         tests_failed++;
         $display("[TB] FAIL flush_cycle_valid: got %b expected 00", bus.cdb_valid);
      end
      tick();
      set_inputs(1'b1, 1'b0, 4'h0, '0);
      #3;
      tests_run++;
      if (bus.fu_ready !== 4'hF) begin
         tests_failed++;
         $display("[TB] FAIL flush_ready: got %h expected F", bus.fu_ready);
      end
      for (int c = 0; c < 4; c++) begin
         tests_run++;
         if (bus.cdb_valid !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL flush_stale%0d: got %b expected 00", c, bus.cdb_valid);
         end
         tick();
         #3;
      end
      tick();
   endtask

   task automatic test_fairness();
      logic [NF*PW-1:0] p;
      int               wait_cyc = 0;
      bit               found    = 1'b0;
      repeat (4) begin
         set_inputs(1'b1, 1'b0, 4'b0111, rand_payload());
         tick();
      end
      p = rand_payload();
      p[3*PW +: PW] = 16'h3333;
      set_inputs(1'b1, 1'b0, 4'b1111, p);
      #3;
      tests_run++;
      if (bus.fu_ready[3] !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL fair_ready3: got %b expected 1", bus.fu_ready[3]);
      end
      tick();
      while (!found && wait_cyc < 10) begin
         set_inputs(1'b1, 1'b0, 4'b0111, rand_payload());
         #3;
         wait_cyc++;
         for (int k = 0; k < NC; k++) begin
            if (bus.cdb_valid[k] === 1'b1 && bus.cdb_src[k*SW +: SW] === 2'd3) begin
               found = 1'b1;
               tests_run++;
               if (bus.cdb_payload[k*PW +: PW] !== 16'h3333) begin
                  tests_failed++;
                  $display("[TB] FAIL fair_payload: got %h expected 3333", bus.cdb_payload[k*PW +: PW]);
               end
            end
         end
         tick();
      end
      tests_run++;
      if (!found || wait_cyc > 2) begin
         tests_failed++;
         $display("[TB] FAIL fair_latency: got found=%0d after %0d cycles expected within 2",
                  found, wait_cyc);
      end
      set_inputs(1'b1, 1'b1, 4'h0, '0);
      tick();
   endtask

`ifdef CDB_WB_STATS_EN
   task automatic test_stats();
      set_inputs(1'b0, 1'b0, 4'h0, '0);
      tick();
      set_inputs(1'b1, 1'b0, 4'hF, rand_payload());
      tick();
      set_inputs(1'b1, 1'b0, 4'h0, '0);
      tick();
      tick();
      tests_run++;
      if (stall_cnt !== {32'd1, 32'd1, 32'd0, 32'd0}) begin
         tests_failed++;
         $display("[TB] FAIL stats_count: got %h expected 1,1,0,0", stall_cnt);
      end
      set_inputs(1'b1, 1'b1, 4'h0, '0);
      tick();
      set_inputs(1'b1, 1'b0, 4'h0, '0);
      tick();
      tests_run++;
      if (stall_cnt !== {32'd1, 32'd1, 32'd0, 32'd0}) begin
         tests_failed++;
         $display("[TB] FAIL stats_flush: got %h expected 1,1,0,0", stall_cnt);
      end
      set_inputs(1'b0, 1'b0, 4'h0, '0);
      tick();
      tests_run++;
      if (stall_cnt !== '0) begin
         tests_failed++;
         $display("[TB] FAIL stats_reset: got %h expected 0", stall_cnt);
      end
      set_inputs(1'b1, 1'b0, 4'h0, '0);
      tick();
   endtask
`endif

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         set_inputs(($urandom_range(0, 99) != 0), ($urandom_range(0, 29) == 0),
                    NF'($urandom), rand_payload());
         #3;
         compute_expected();
         tests_run++;
         if (bus.fu_ready !== exp_ready || bus.cdb_valid !== exp_valid ||
             bus.cdb_payload !== exp_payload || bus.cdb_src !== exp_src) begin
            tests_failed++;
            $display("[TB] FAIL random_cycle%0d: got r=%h v=%b p=%h s=%b expected r=%h v=%b p=%h s=%b", c,
                     bus.fu_ready, bus.cdb_valid, bus.cdb_payload, bus.cdb_src,
                     exp_ready, exp_valid, exp_payload, exp_src);
         end
`ifdef CDB_WB_STATS_EN
         for (int i = 0; i < NF; i++) begin
            tests_run++;
            if (stall_cnt[i*32 +: 32] !== 32'(m_stall[i])) begin
               tests_failed++;
               $display("[TB] FAIL random_stall%0d: got %0d expected %0d", i,
                        stall_cnt[i*32 +: 32], m_stall[i]);
            end
         end
`endif
         tick();
      end
   endtask

   initial begin
      for (int i = 0; i < NF; i++) m_stall[i] = 0;
      m_rr = 0;
      set_inputs(1'b0, 1'b0, 4'h0, '0);
      tick();
      test_reset();
      test_single_push();
      test_all_channels();
      test_back_to_back();
      test_flush();
      test_fairness();
`ifdef CDB_WB_STATS_EN
      test_stats();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
